// File: rtl/bram_req_arbiter.sv
// Round-robin arbiter that shares one single-port BRAM controller between NUM_REQ clients,
// sequencing each access from issue to response with a watchdog against a hung controller.
module bram_req_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_REQ    = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                               system_clk,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [NUM_REQ-1:0]                 req_mode,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]                 req_ack,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic                               rsp_err,
    output logic [DATA_WIDTH-1:0]              rsp_rdata,
    output logic                               busy,
    output logic [$clog2(NUM_REQ)-1:0]         grant_id,
    output logic                               ctrl_run,
    output logic                               ctrl_mode,
    output logic [ADDR_WIDTH-1:0]              ctrl_addr,
    output logic [DATA_WIDTH-1:0]              ctrl_wdata,
    input  logic                               ctrl_idle,
    input  logic                               ctrl_done,
    input  logic                               ctrl_read_valid,
    input  logic [DATA_WIDTH-1:0]              ctrl_read_data
);

    localparam int IDW = $clog2(NUM_REQ);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RDATA = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]            r_state;
    logic [IDW-1:0]        r_last;
    logic [IDW-1:0]        r_grant_id;
    logic [NUM_REQ-1:0]    r_req_ack;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic                  r_rsp_err;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_ctrl_run;
    logic                  r_ctrl_mode;
    logic [ADDR_WIDTH-1:0] r_ctrl_addr;
    logic [DATA_WIDTH-1:0] r_ctrl_wdata;
    logic [15:0]           r_cnt;

    logic                  w_found;
    logic [IDW-1:0]        w_winner;
    logic [IDW-1:0]        w_idx;
    logic [15:0]           w_cnt_next;
    logic                  w_timeout;

    function automatic logic [NUM_REQ-1:0] f_onehot(input logic [IDW-1:0] id);
        logic [NUM_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // Round-robin pick: first active request after the previous owner.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDW'((int'(r_last) + k) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end else begin
                w_found  = w_found;
            end
        end
    end

    // Watchdog compare; a zero TIMEOUT never fires.
    always_comb begin
        w_cnt_next = r_cnt + 16'd1;
        if (TIMEOUT != 0) begin
            w_timeout = (w_cnt_next >= 16'(TIMEOUT));
        end else begin
            w_timeout = 1'b0;
        end
    end

    // Sequencer FSM with registered controller drive and client responses.
    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_last       <= IDW'(NUM_REQ - 1);
            r_grant_id   <= '0;
            r_req_ack    <= '0;
            r_rsp_valid  <= '0;
            r_rsp_err    <= 1'b0;
            r_rsp_rdata  <= '0;
            r_ctrl_run   <= 1'b0;
            r_ctrl_mode  <= 1'b0;
            r_ctrl_addr  <= '0;
            r_ctrl_wdata <= '0;
            r_cnt        <= 16'd0;
        end else begin
            r_req_ack   <= '0;
            r_rsp_valid <= '0;
            r_ctrl_run  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found && ctrl_idle) begin
                        r_grant_id   <= w_winner;
                        r_ctrl_mode  <= req_mode[w_winner];
                        r_ctrl_addr  <= req_addr[w_winner * ADDR_WIDTH +: ADDR_WIDTH];
                        r_ctrl_wdata <= req_wdata[w_winner * DATA_WIDTH +: DATA_WIDTH];
                        r_req_ack    <= f_onehot(w_winner);
                        r_ctrl_run   <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= 16'd0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // done has priority over a simultaneous timeout
                    if (ctrl_done) begin
                        if (r_ctrl_mode) begin
                            r_rsp_valid <= f_onehot(r_grant_id);
                            r_rsp_err   <= 1'b0;
                            r_state     <= S_RESP;
                        end else begin
                            r_cnt   <= w_cnt_next;
                            r_state <= S_RDATA;
                        end
                    end else if (w_timeout) begin
                        r_rsp_valid <= f_onehot(r_grant_id);
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                S_RDATA: begin
                    if (ctrl_read_valid) begin
                        r_rsp_valid <= f_onehot(r_grant_id);
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= ctrl_read_data;
                        r_state     <= S_RESP;
                    end else if (w_timeout) begin
                        r_rsp_valid <= f_onehot(r_grant_id);
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                S_RESP: begin
                    r_last  <= r_grant_id;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ack    = r_req_ack;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_err    = r_rsp_err;
    assign rsp_rdata  = r_rsp_rdata;
    assign busy       = (r_state != S_IDLE);
    assign grant_id   = r_grant_id;
    assign ctrl_run   = r_ctrl_run;
    assign ctrl_mode  = r_ctrl_mode;
    assign ctrl_addr  = r_ctrl_addr;
    assign ctrl_wdata = r_ctrl_wdata;

endmodule

// File: tb/tb_bram_req_arbiter.sv
// Bench for bram_req_arbiter: directed scenarios plus randomized traffic against a
// round-robin/memory reference model, with the controller played from the stimulus thread.
module tb_bram_req_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 12;
    localparam int NR  = 2;
    localparam int TO  = 64;
    localparam int IDW = $clog2(NR);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NR-1:0]        req = '0;
    logic [NR-1:0]        req_mode = '0;
    logic [NR*AW-1:0]     req_addr = '0;
    logic [NR*DW-1:0]     req_wdata = '0;
    logic [NR-1:0]        req_ack;
    logic [NR-1:0]        rsp_valid;
    logic                 rsp_err;
    logic [DW-1:0]        rsp_rdata;
    logic                 busy;
    logic [IDW-1:0]       grant_id;
    logic                 ctrl_run;
    logic                 ctrl_mode;
    logic [AW-1:0]        ctrl_addr;
    logic [DW-1:0]        ctrl_wdata;
    logic                 ctrl_idle = 1'b1;
    logic                 ctrl_done = 1'b0;
    logic                 ctrl_read_valid = 1'b0;
    logic [DW-1:0]        ctrl_read_data = '0;

    always #5 clk = ~clk;

    bram_req_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .system_clk(clk), .reset(rst_n),
        .req(req), .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .busy(busy), .grant_id(grant_id),
        .ctrl_run(ctrl_run), .ctrl_mode(ctrl_mode), .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
        .ctrl_idle(ctrl_idle), .ctrl_done(ctrl_done), .ctrl_read_valid(ctrl_read_valid),
        .ctrl_read_data(ctrl_read_data)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: client view of memory, controller's memory, rr pointer, pending requests.
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] ctl_mem [int];
    int            m_last = NR - 1;
    bit            pend   [NR];
    logic          p_mode [NR];
    logic [AW-1:0] p_addr [NR];
    logic [DW-1:0] p_data [NR];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_winner();
        for (int k = 1; k <= NR; k++) begin
            if (pend[(m_last + k) % NR]) return (m_last + k) % NR;
        end
        return -1;
    endfunction

    function automatic bit any_pend();
        for (int i = 0; i < NR; i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic set_req(input int i, input logic m, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend[i] = 1'b1; p_mode[i] = m; p_addr[i] = a; p_data[i] = d;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NR; i++) begin
            req[i]               = pend[i];
            req_mode[i]          = p_mode[i];
            req_addr[i*AW +: AW] = p_addr[i];
            req_wdata[i*DW +: DW] = p_data[i];
        end
    endtask

    // Waits for the grant and checks the latched request; returns 0 if no ctrl_run came.
    task automatic wait_grant(output int w, output bit ok);
        int n;
        w = model_winner();
        n = 0;
        do begin @(negedge clk); n++; end while (!ctrl_run && n < 10);
        chk("run_seen", 64'(ctrl_run), 64'd1);
        ok = ctrl_run;
        if (!ok || w < 0) begin
            ok = 1'b0;
            return;
        end
        chk("grant_id", 64'(grant_id), 64'(w));
        chk("req_ack", 64'(req_ack), 64'd1 << w);
        chk("ctrl_mode", 64'(ctrl_mode), 64'(p_mode[w]));
        chk("ctrl_addr", 64'(ctrl_addr), 64'(p_addr[w]));
        chk("ctrl_wdata", 64'(ctrl_wdata), 64'(p_data[w]));
        chk("busy", 64'(busy), 64'd1);
        pend[w] = 1'b0;
        req[w]  = 1'b0;
        ctrl_idle = 1'b0;
    endtask

    task automatic txn(input int dly, input int rgap, output int g);
        int w; bit ok; logic m; logic [AW-1:0] a; logic [DW-1:0] d; logic [DW-1:0] exp_rd;
        g = -1;
        wait_grant(w, ok);
        if (!ok) return;
        m = p_mode[w]; a = p_addr[w]; d = p_data[w];
        for (int c = 0; c < dly; c++) begin
            @(negedge clk);
            if (c == 0) chk("run_pulse", 64'(ctrl_run), 64'd0);
        end
        ctrl_done = 1'b1;
        ctrl_idle = 1'b1;
        if (ctrl_mode) ctl_mem[int'(ctrl_addr)] = ctrl_wdata;
        @(negedge clk);
        ctrl_done = 1'b0;
        if (m) begin
            chk("wr_rsp_valid", 64'(rsp_valid), 64'd1 << w);
            chk("wr_rsp_err", 64'(rsp_err), 64'd0);
            ref_mem[int'(a)] = d;
        end else begin
            chk("rd_early", 64'(rsp_valid), 64'd0);
            for (int c = 0; c < rgap; c++) @(negedge clk);
            ctrl_read_valid = 1'b1;
            ctrl_read_data  = ctl_mem.exists(int'(ctrl_addr)) ? ctl_mem[int'(ctrl_addr)] : '0;
            @(negedge clk);
            ctrl_read_valid = 1'b0;
            ctrl_read_data  = $urandom;
            exp_rd = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
            chk("rd_rsp_valid", 64'(rsp_valid), 64'd1 << w);
            chk("rd_rsp_err", 64'(rsp_err), 64'd0);
            chk("rd_rdata", 64'(rsp_rdata), 64'(exp_rd));
        end
        m_last = w;
        g = w;
        @(negedge clk);
        chk("rsp_pulse", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g; int w; bit ok; int g0;
        for (int i = 0; i < NR; i++) begin pend[i] = 1'b0; p_mode[i] = 1'b0; p_addr[i] = '0; p_data[i] = '0; end
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_outs", {ctrl_run, ctrl_mode, rsp_err, grant_id, req_ack, rsp_valid}, 64'd0);
        chk("rst_data", 64'(ctrl_addr) | 64'(ctrl_wdata) | 64'(rsp_rdata), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Both clients request straight out of reset: 0 first, then 1.
        set_req(0, 1'b1, 12'h020, 32'h1111_0000);
        set_req(1, 1'b1, 12'h021, 32'h2222_0000);
        drive_reqs();
        txn(2, 0, g0);
        txn(1, 0, g);
        chk("t3_first", 64'(g0), 64'd0);
        chk("t3_second", 64'(g), 64'd1);

        // Continuous contention alternates owners.
        set_req(0, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), $urandom);
        set_req(1, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), $urandom);
        drive_reqs();
        for (int i = 0; i < 8; i++) begin
            txn($urandom_range(1, 4), $urandom_range(0, 2), g);
            chk("t4_seq", 64'(g), 64'(i % 2));
            if (i < 7 && g >= 0) begin
                set_req(g, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), $urandom);
                drive_reqs();
            end
        end
        while (any_pend()) txn(2, 1, g);

        // Single write then read-back of 0x010.
        set_req(0, 1'b1, 12'h010, 32'hDEAD_BEEF);
        drive_reqs();
        txn(2, 0, g);
        set_req(0, 1'b0, 12'h010, $urandom);
        drive_reqs();
        txn(3, 1, g);
        chk("t2_rdata", 64'(rsp_rdata), 64'h0000_0000_DEAD_BEEF);

        // Randomized mixed traffic.
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), $urandom);
            end
            if (!any_pend())
                set_req($urandom_range(0, NR - 1), 1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), $urandom);
            drive_reqs();
            txn($urandom_range(1, 5), $urandom_range(0, 3), g);
        end
        while (any_pend()) txn(1, 0, g);

        // Hung controller: watchdog response 64 cycles after entering the wait state.
        set_req(1, 1'b0, 12'h005, $urandom);
        drive_reqs();
        wait_grant(w, ok);
        if (ok) begin
            for (int c = 1; c <= TO; c++) @(negedge clk);
            chk("wd_not_early", 64'(rsp_valid), 64'd0);
            @(negedge clk);
            chk("wd_rsp_valid", 64'(rsp_valid), 64'd1 << w);
            chk("wd_rsp_err", 64'(rsp_err), 64'd1);
            chk("wd_rdata", 64'(rsp_rdata), 64'd0);
            m_last = w;
        end
        ctrl_idle = 1'b1;
        @(negedge clk);

        // Reset while waiting for read data: silent abort, then normal service of client 1.
        set_req(0, 1'b0, 12'h010, $urandom);
        drive_reqs();
        wait_grant(w, ok);
        @(negedge clk);
        ctrl_done = 1'b1;
        ctrl_idle = 1'b1;
        @(negedge clk);
        ctrl_done = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("r6_outs", {ctrl_run, ctrl_mode, rsp_err, grant_id, req_ack, rsp_valid, busy}, 64'd0);
        chk("r6_data", 64'(ctrl_addr) | 64'(ctrl_wdata) | 64'(rsp_rdata), 64'd0);
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        drive_reqs();
        m_last = NR - 1;
        repeat (2) begin
            @(negedge clk);
            chk("r6_no_rsp", 64'(rsp_valid), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        set_req(1, 1'b1, 12'h033, 32'hCAFE_F00D);
        drive_reqs();
        txn(2, 0, g);
        chk("r6_grant", 64'(g), 64'd1);
        set_req(1, 1'b0, 12'h033, $urandom);
        drive_reqs();
        txn(1, 2, g);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
